// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared types, constants and PC helpers for the fetch controller
// Revision  : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INST_BYTES);
  endfunction

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo : DEPTH-entry prefetch FIFO of {pc, inst} with a registered head
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             empty;
  logic             do_push;
  logic             do_pop;
  logic [AW:0]      remain;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && !flush && (!full || do_pop);
  assign remain  = count - (AW+1)'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // head is a separate register so it holds its last value once the FIFO empties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(do_pop);
      wr_ptr <= wr_ptr + AW'(do_push);
      count  <= remain + (AW+1)'(do_push);
      if (remain != '0)
        head <= mem[rd_ptr + AW'(do_pop)];
      else if (do_push)
        head <= push_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_controller.sv
// ============================================================================
// fetch_controller : fetch PC, BOOT/RUN/HALT FSM and prefetch FIFO front end
// Optional feature : FETCH_MISALIGN_CHECK_EN (sticky misalign flag + halt)
// Revision         : 1.0
// ============================================================================
`default_nettype none

module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_inst,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);

  state_t                state;
  logic [XLEN-1:0]       fetch_pc;
  logic                  pop;
  logic                  push;
  logic                  full;
  logic [2*XLEN-1:0]     head;
  logic [$clog2(DEPTH):0] count;

  assign imem_pc    = fetch_pc;
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;
  // redirect outranks fetch; a full FIFO may still accept when decode pops
  assign push       = (state == ST_RUN) && !halt && !redirect_valid && (!full || pop);
  assign inst       = head[XLEN-1:0];
  assign inst_pc    = head[2*XLEN-1:XLEN];

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_data ({fetch_pc, imem_inst}),
    .head      (head),
    .count     (count),
    .full      (full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_BOOT;
      fetch_pc <= RESET_PC;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign <= 1'b0;
`endif
    end else begin
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN:  if (halt) state <= ST_HALT;
`ifdef FETCH_MISALIGN_CHECK_EN
        ST_HALT: if (!halt && !misalign) state <= ST_RUN;
`else
        ST_HALT: if (!halt) state <= ST_RUN;
`endif
        default: state <= ST_BOOT;
      endcase

      if (redirect_valid) begin
        fetch_pc <= align_pc(redirect_pc);
`ifdef FETCH_MISALIGN_CHECK_EN
        // a misaligned target parks the controller until the next reset
        if (redirect_pc[1:0] != 2'b00) begin
          misalign <= 1'b1;
          state    <= ST_HALT;
        end
`endif
      end else if (push) begin
        fetch_pc <= next_pc(fetch_pc);
      end
    end
  end

endmodule

`default_nettype wire
